ema_seq_ctrl: RTL
=================

Name: ema_seq_ctrl

Overview:
Sequencer that turns a stream of 8-bit signed samples into exponential-moving-average outputs, y = y_prev + alpha*(x - y_prev). It is the initiator side of the ALU operand/result interface: it issues mode/op1/op2/valid, waits for the ALU result/valid and chains three ALU ops per sample (ADD, MULT, ADD). It sits between the sample source (valid/ready) and the filter output sink (valid/ready), with the ALU instantiated alongside.

Parameters:
Win, 8, sample width; ALU op1 width Win, op2 width Win+1
Wout, 16, ALU result width
Walpha, 7, alpha width, unsigned Q0.(Walpha), must equal Win-1

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
in_valid_i  in  1  sample valid
in_ready_o  out  1  controller can accept a sample
x_i  in  Win  signed input sample
alpha_i  in  Walpha  smoothing factor, sampled on accept
out_valid_o  out  1  filtered sample valid
out_ready_i  in  1  sink accepts output
y_o  out  Win  signed filtered sample
alu_mode_o  out  2  0=IDLE, 1=ADD, 2=MULT
alu_op1_o  out  Win  signed op1
alu_op2_o  out  Win+1  signed op2
alu_valid_o  out  1  op issue strobe
alu_res_i  in  Wout  signed ALU result
alu_valid_i  in  1  ALU result valid (one cycle after issue)

Behaviour:
- Reset (async, any state incl. mid-op): state=IDLE; in_ready_o=1; out_valid_o=0; y_o=0; alu_mode_o=0, alu_op1_o=0, alu_op2_o=0, alu_valid_o=0; y_prev=0; primed=0. All outputs registered.
- States: IDLE, SUB_ISS, SUB_WAIT, MUL_ISS, MUL_WAIT, ADD_ISS, ADD_WAIT, OUT.
- IDLE: in_ready_o=1. Accept on in_valid_i & in_ready_o; latch x, alpha. If primed=0: y_o<=x, y_prev<=x, primed<=1, go OUT (out_valid_o high on cycle after accept). Else go SUB_ISS.
- *_ISS states drive alu_valid_o=1 for exactly one cycle with mode/operands; all other states drive mode=0, operands=0, alu_valid_o=0.
- SUB_ISS: mode=ADD, op1=x, op2=-sext(y_prev) (Win+1 bits). SUB_WAIT: on alu_valid_i, diff<=alu_res_i[Win:0].
- MUL_ISS: mode=MULT, op1={0,alpha}, op2=diff. MUL_WAIT: on alu_valid_i, delta<=(alu_res_i >>> Walpha)[Win:0] (arithmetic shift, floor rounding).
- ADD_ISS: mode=ADD, op1=y_prev, op2=delta. ADD_WAIT: on alu_valid_i, y_new=saturate(alu_res_i) to [-2^(Win-1), 2^(Win-1)-1]; y_o<=y_new, y_prev<=y_new; go OUT.
- WAIT states hold indefinitely until alu_valid_i; alu_valid_i in any other state ignored.
- OUT: out_valid_o=1, y_o stable until out_valid_o & out_ready_i; then out_valid_o<=0, go IDLE. in_ready_o=0 in every non-IDLE state (one sample in flight).
- Latency with ideal ALU and sink: primed sample accepted at edge k -> out_valid_o high after edge k+7; first sample after reset -> after edge k+1. Throughput: one sample per 8 cycles (2 for first).
- Math guarantees y_new between y_prev and x; saturation is defensive only, must still be implemented.
- alpha=0 -> y unchanged; alpha=2^Walpha-1 -> y approaches x.

Test Plan:
- Reset then x=50, alpha=64 -> out_valid_o high 1 cycle after accept, y_o=50, no alu_valid_o pulses.
- Primed y=50; x=100, alpha=64 -> ALU sees ADD(100,-50), MULT(64,50), ADD(50,25); y_o=75, out_valid_o 7 cycles after accept.
- y=75; x=-100, alpha=64 -> diff=-175, product=-11200, delta=-88, y_o=-13.
- y=-13; x=120, alpha=0 -> y_o=-13; then x=127, y=127, alpha=127 -> y_o=127 (no overflow).
- Backpressure: out_ready_i low 5 cycles in OUT -> out_valid_o=1, y_o stable, in_ready_o=0 with in_valid_i held high; sample accepted only after handshake.
- rst asserted mid-op (MUL_WAIT) -> all outputs 0 immediately, in_ready_o=1 after release; next x=-20 passes through as y_o=-20 (primed cleared).

Source files
------------

// File: rtl/ema_seq_ctrl.sv
// rtl/ema_seq_ctrl.sv - EMA sequencer that chains ADD/MULT/ADD ops on an external ALU per sample
module ema_seq_ctrl #(
  parameter int Win    = 8,
  parameter int Wout   = 16,
  parameter int Walpha = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [Win-1:0]    x_i,
  input  logic [Walpha-1:0] alpha_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [Win-1:0]    y_o,
  output logic [1:0]        alu_mode_o,
  output logic [Win-1:0]    alu_op1_o,
  output logic [Win:0]      alu_op2_o,
  output logic              alu_valid_o,
  input  logic [Wout-1:0]   alu_res_i,
  input  logic              alu_valid_i
);

  localparam logic [1:0]     MODE_IDLE = 2'd0;
  localparam logic [1:0]     MODE_ADD  = 2'd1;
  localparam logic [1:0]     MODE_MULT = 2'd2;
  localparam logic [Win-1:0] Y_MAX     = {1'b0, {(Win-1){1'b1}}};
  localparam logic [Win-1:0] Y_MIN     = {1'b1, {(Win-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SUB_ISS,
    S_SUB_WAIT,
    S_MUL_ISS,
    S_MUL_WAIT,
    S_ADD_ISS,
    S_ADD_WAIT,
    S_OUT
  } state_t;

  state_t            r_state;
  logic              r_primed;
  logic [Win-1:0]    r_y_prev;
  logic [Walpha-1:0] r_alpha;

  logic [Win:0]      w_neg_y_prev;
  logic [Win:0]      w_delta;
  logic [Win-1:0]    w_y_sat;

  assign w_neg_y_prev = -{r_y_prev[Win-1], r_y_prev};

  // Product >>> Walpha then keep Win+1 bits: with Wout = Walpha+Win+1 this is
  // exactly the top slice, and slicing a two's-complement value floors.
  assign w_delta = alu_res_i[Walpha +: (Win+1)];

  always_comb begin
    w_y_sat = alu_res_i[Win-1:0];
    if ($signed(alu_res_i) > $signed({{(Wout-Win){1'b0}}, Y_MAX}))
      w_y_sat = Y_MAX;
    else if ($signed(alu_res_i) < $signed({{(Wout-Win){1'b1}}, Y_MIN}))
      w_y_sat = Y_MIN;
  end

  // ALU issue outputs are loaded on entry to each *_ISS state and cleared on
  // every other edge, so the strobe lasts exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_primed    <= 1'b0;
      r_y_prev    <= '0;
      r_alpha     <= '0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      y_o         <= '0;
      alu_mode_o  <= MODE_IDLE;
      alu_op1_o   <= '0;
      alu_op2_o   <= '0;
      alu_valid_o <= 1'b0;
    end else begin
      alu_mode_o  <= MODE_IDLE;
      alu_op1_o   <= '0;
      alu_op2_o   <= '0;
      alu_valid_o <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (in_valid_i && in_ready_o) begin
            r_alpha    <= alpha_i;
            in_ready_o <= 1'b0;
            if (!r_primed) begin
              y_o         <= x_i;
              r_y_prev    <= x_i;
              r_primed    <= 1'b1;
              out_valid_o <= 1'b1;
              r_state     <= S_OUT;
            end else begin
              alu_mode_o  <= MODE_ADD;
              alu_op1_o   <= x_i;
              alu_op2_o   <= w_neg_y_prev;
              alu_valid_o <= 1'b1;
              r_state     <= S_SUB_ISS;
            end
          end
        end

        S_SUB_ISS: r_state <= S_SUB_WAIT;

        S_SUB_WAIT: begin
          if (alu_valid_i) begin
            alu_mode_o  <= MODE_MULT;
            alu_op1_o   <= {1'b0, r_alpha};
            alu_op2_o   <= alu_res_i[Win:0];
            alu_valid_o <= 1'b1;
            r_state     <= S_MUL_ISS;
          end
        end

        S_MUL_ISS: r_state <= S_MUL_WAIT;

        S_MUL_WAIT: begin
          if (alu_valid_i) begin
            alu_mode_o  <= MODE_ADD;
            alu_op1_o   <= r_y_prev;
            alu_op2_o   <= w_delta;
            alu_valid_o <= 1'b1;
            r_state     <= S_ADD_ISS;
          end
        end

        S_ADD_ISS: r_state <= S_ADD_WAIT;

        S_ADD_WAIT: begin
          if (alu_valid_i) begin
            y_o         <= w_y_sat;
            r_y_prev    <= w_y_sat;
            out_valid_o <= 1'b1;
            r_state     <= S_OUT;
          end
        end

        S_OUT: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
